// File: rtl/gift_sbox_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : gift_sbox_share_sched
// Brief    : Nibble/stage scheduler for the 3-share masked GIFT S-box pipeline,
//            stalling the whole datapath while randomness is unavailable.
// Revision : 1.0
// ============================================================================
module gift_sbox_share_sched #(
   parameter int NIBBLES = 16,
   parameter int STAGES  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rnd_valid,
   output logic              rnd_take,
   output logic              busy,
   output logic              done,
   output logic [3:0]        sb_in_sel,
   output logic [STAGES-1:0] sb_en,
   output logic              sb_out_we,
   output logic [3:0]        sb_out_sel
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [4:0] C_NIB      = 5'(NIBBLES);
   localparam logic [4:0] C_LAST_ISS = 5'(NIBBLES - 1);
   localparam logic [3:0] C_LAST_WB  = 4'(NIBBLES - 1);

   state_t            r_state;
   logic [4:0]        r_iss;
   logic [3:0]        r_wb;
   logic [STAGES-1:0] r_v;

   logic w_adv;
   logic w_issue;
   logic w_write;

   // A stalled cycle freezes every stage so shares never slide across stages.
   assign w_adv   = busy & rnd_valid;
   assign w_issue = w_adv & (r_iss < C_NIB);
   assign w_write = w_adv & r_v[STAGES-1];

   always_comb begin
      sb_en    = '0;
      sb_en[0] = w_issue;
      for (int k = 1; k < STAGES; k++) begin
         sb_en[k] = w_adv & r_v[k-1];
      end
   end

   assign rnd_take   = w_adv;
   assign sb_in_sel  = w_issue ? r_iss[3:0] : 4'd0;
   assign sb_out_we  = w_write;
   assign sb_out_sel = w_write ? r_wb : 4'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         r_iss   <= '0;
         r_wb    <= '0;
         r_v     <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  busy    <= 1'b1;
                  r_iss   <= '0;
                  r_wb    <= '0;
                  r_v     <= '0;
               end
            end
            RUN, DRAIN: begin
               if (w_adv) begin
                  for (int k = STAGES - 1; k > 0; k--) begin
                     r_v[k] <= r_v[k-1];
                  end
                  r_v[0] <= w_issue;
                  if (w_issue) begin
                     r_iss <= r_iss + 5'd1;
                     if ((r_state == RUN) && (r_iss == C_LAST_ISS)) begin
                        r_state <= DRAIN;
                     end
                  end
                  if (w_write) begin
                     if ((r_state == DRAIN) && (r_wb == C_LAST_WB)) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        r_wb <= r_wb + 4'd1;
                     end
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gift_sbox_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gift_sbox_share_sched
// Brief    : Scoreboard bench for gift_sbox_share_sched (16x4 and 2x1 builds).
// Revision : 1.0
// ============================================================================
module tb_gift_sbox_share_sched;

   localparam int N = 16;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst, start, start2, rnd_valid;

   logic         take, busy, done, we;
   logic [3:0]   in_sel, out_sel;
   logic [S-1:0] en;

   logic         take2, busy2, done2, we2;
   logic [3:0]   in_sel2, out_sel2;
   logic [0:0]   en2;

   always #5 clk = ~clk;

   gift_sbox_share_sched #(.NIBBLES(N), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .rnd_valid(rnd_valid),
      .rnd_take(take), .busy(busy), .done(done), .sb_in_sel(in_sel),
      .sb_en(en), .sb_out_we(we), .sb_out_sel(out_sel)
   );

   gift_sbox_share_sched #(.NIBBLES(2), .STAGES(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .rnd_valid(rnd_valid),
      .rnd_take(take2), .busy(busy2), .done(done2), .sb_in_sel(in_sel2),
      .sb_en(en2), .sb_out_we(we2), .sb_out_sel(out_sel2)
   );

   typedef struct {
      int c;
      int idx;
   } ev_t;

   ev_t iss_q[$];
   ev_t wb_q[$];
   int  done_q[$];
   ev_t e_i, e_w;

   int total = 0;
   int bad = 0;
   int rel = 0;
   int stall_lo = 1000;
   int stall_hi = 0;
   int take_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, rel);
      end
   endtask

   function automatic bit vld(input int c);
      return !(c >= stall_lo && c <= stall_hi);
   endfunction

   // Expected events: the j-th advancing cycle after start issues nibble j and
   // writes back nibble j-S; done follows the last advancing cycle.
   task automatic push_layer(input int s0);
      int j;
      j = 0;
      for (int c = s0 + 1; j < N + S; c++) begin
         if (vld(c)) begin
            if (j < N)  iss_q.push_back('{c, j});
            if (j >= S) wb_q.push_back('{c, j - S});
            if (j == N + S - 1) done_q.push_back(c + 1);
            j++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rel++;
      rnd_valid = vld(rel);
   endtask

   task automatic begin_layer();
      rel       = 0;
      start     = 1'b1;
      rnd_valid = vld(0);
      take_cnt  = 0;
      push_layer(0);
   endtask

   task automatic end_chk(input int exp_take);
      chk("iss_left",  iss_q.size(),  0);
      chk("wb_left",   wb_q.size(),   0);
      chk("done_left", done_q.size(), 0);
      chk("take_cnt",  take_cnt,      exp_take);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_en"},   en, 0);
      chk({tag, "_we"},   we, 0);
      chk({tag, "_take"}, take, 0);
      chk({tag, "_isel"}, in_sel, 0);
      chk({tag, "_osel"}, out_sel, 0);
   endtask

   always @(negedge clk) begin
      if (en[0]) begin
         if (iss_q.size() == 0) chk("iss_extra", rel, 32'hFFFF_FFFF);
         else begin
            e_i = iss_q.pop_front();
            chk("iss_cyc", rel, e_i.c);
            chk("iss_sel", in_sel, e_i.idx);
         end
      end
      if (we) begin
         if (wb_q.size() == 0) chk("wb_extra", rel, 32'hFFFF_FFFF);
         else begin
            e_w = wb_q.pop_front();
            chk("wb_cyc", rel, e_w.c);
            chk("wb_sel", out_sel, e_w.idx);
         end
      end
      if (done) begin
         chk("done_busy", busy, 0);
         if (done_q.size() == 0) chk("done_extra", rel, 32'hFFFF_FFFF);
         else chk("done_cyc", rel, done_q.pop_front());
      end
      if (take) take_cnt++;
      if (busy && !rnd_valid) begin
         chk("stall_en", en, 0);
         chk("stall_we", we, 0);
         chk("stall_take", take, 0);
      end
   end

   int b_en[5]   = '{1, 1, 0, 0, 0};
   int b_isel[5] = '{0, 1, 0, 0, 0};
   int b_we[5]   = '{0, 1, 1, 0, 0};
   int b_osel[5] = '{0, 0, 1, 0, 0};
   int b_done[5] = '{0, 0, 0, 1, 0};
   int b_busy[5] = '{1, 1, 1, 0, 0};

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0; rnd_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      step();

      // Plain layer, randomness always present
      begin_layer();
      step(); start = 1'b0;
      while (rel < 24) step();
      end_chk(N + S);

      // Randomness missing in cycles 3 and 4
      stall_lo = 3; stall_hi = 4;
      begin_layer();
      step(); start = 1'b0;
      while (rel < 26) step();
      end_chk(N + S);
      stall_lo = 1000; stall_hi = 0;

      // Extra start mid-layer is ignored
      begin_layer();
      step(); start = 1'b0;
      while (rel < 30) begin
         step();
         start = (rel == 5);
         if (rel >= 21) chk("idle_busy", busy, 0);
      end
      end_chk(N + S);

      // Reset in cycle 10, restart in cycle 12
      begin_layer();
      step(); start = 1'b0;
      while (rel < 10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      iss_q.delete(); wb_q.delete(); done_q.delete();
      chk_zero("midrst");
      step();
      start = 1'b1;
      push_layer(12);
      step(); start = 1'b0;
      while (rel < 36) step();
      end_chk(10 + N + S);

      // start held high: back-to-back layers
      begin_layer();
      push_layer(N + S + 1);
      step();
      while (rel < 50) begin
         if (rel == 41) start = 1'b0;
         if (rel == 22) chk("cont_busy22", busy, 1);
         step();
      end
      end_chk(2 * (N + S));

      // Minimal build: 2 nibbles, 1 stage
      rel = 0;
      start2 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         start2 = 1'b0;
         chk("m_en",   en2[0], b_en[c-1]);
         chk("m_we",   we2,    b_we[c-1]);
         chk("m_done", done2,  b_done[c-1]);
         chk("m_busy", busy2,  b_busy[c-1]);
         if (b_en[c-1] != 0) chk("m_isel", in_sel2,  b_isel[c-1]);
         if (b_we[c-1] != 0) chk("m_osel", out_sel2, b_osel[c-1]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gift_sbox_share_sched.md
# gift_sbox_share_sched

Sequencing controller for the 3-share, second-order masked GIFT S-box datapath. It schedules the nibbles of one state layer through the pipelined component-function stages: each stage's register enables, the input nibble index and the write-back nibble index. It also stalls the whole datapath whenever fresh randomness is unavailable. It sits between the round controller (start/done) and the shared S-box pipeline plus state register file.

## Interface
- NIBBLES, 16: nibbles per layer; legal range 2..16.
- STAGES, 4: register stages in the shared S-box datapath, covering component-function and compression stages; legal range 1..8.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one layer; sampled only while busy=0.
- rnd_valid  in  1  fresh randomness word present this cycle.
- rnd_take  out  1  randomness word consumed this cycle.
- busy  out  1  layer in progress.
- done  out  1  one-cycle pulse after the last write-back.
- sb_in_sel  out  4  nibble index fed to datapath stage 0.
- sb_en  out  STAGES  per-stage share-register enable; bit k is stage k.
- sb_out_we  out  1  write the stage STAGES-1 shares back to the state.
- sb_out_sel  out  4  nibble index being written back.

## Operation
- FSM states:
  - IDLE: busy=0.
  - RUN: issuing nibbles.
  - DRAIN: all nibbles issued, pipeline not empty.
- Transitions:
  - IDLE→RUN when start=1.
  - RUN→DRAIN on the advancing cycle that issues nibble NIBBLES-1.
  - DRAIN→IDLE on the advancing cycle that writes nibble NIBBLES-1. done is registered high for the following cycle.
  - With STAGES=1 and NIBBLES small, the transitions still follow the same rules; the pipeline is never skipped.
- Internal state:
  - issue counter iss (0..NIBBLES)
  - write counter wb (0..NIBBLES-1)
  - pipeline valid vector v[STAGES-1:0]
- advance = busy & rnd_valid. Every output below is gated by advance.
  - sb_en[0] = advance & (iss < NIBBLES); sb_in_sel = iss.
  - sb_en[k] = advance & v[k-1], for k ≥ 1.
  - sb_out_we = advance & v[STAGES-1]; sb_out_sel = wb.
  - rnd_take = advance.
- On advance:
  - v shifts up one position, with v[0] taking sb_en[0].
  - iss increments when sb_en[0]=1.
  - wb increments when sb_out_we=1.
- When advance=0, all state is frozen: no enable, no counter change, no randomness consumed. Shares must never mix across stages.
- Index counters never wrap within a layer. Both are cleared to 0 on the IDLE→RUN transition.
- start while busy=1 is ignored and not queued.
- start in the done cycle is accepted, because busy=0 in that cycle.

## Timing
- Reset values: all outputs 0, FSM IDLE, iss=0, wb=0, v=0.
- Reset mid-layer:
  - All state is cleared on the next edge.
  - No done pulse is produced.
  - Any partially written layer is abandoned; the round controller owns recovery.
- Let start be sampled in cycle 0 with no stalls:
  - busy=1 in cycles 1..NIBBLES+STAGES.
  - Nibble i is issued in cycle 1+i.
  - Nibble i is written back in cycle 1+i+STAGES.
  - done=1 in cycle NIBBLES+STAGES+1, with busy=0 in that same cycle.
- Each cycle with rnd_valid=0 while busy delays every later event by exactly one cycle.
- rnd_take pulses exactly NIBBLES+STAGES times per layer, whatever the stalls.
- Outputs are combinational from registered state and rnd_valid. There is no combinational path from start to any output except through the registered FSM.

## Test plan
- Defaults, rst then start in cycle 0, rnd_valid=1 throughout:
  - sb_en[0] high in cycles 1..16 with sb_in_sel 0..15.
  - sb_out_we high in cycles 5..20 with sb_out_sel 0..15.
  - done only in cycle 21; 20 rnd_take pulses.
- Defaults, rnd_valid=0 in cycles 3 and 4:
  - All enables, sb_out_we and rnd_take are 0 in those cycles.
  - Issues occur in cycles 1, 2 and 5..18; writes in cycles 7..22; done in cycle 23.
  - Every index appears exactly once, in order.
- start pulsed again in cycle 5 mid-layer:
  - Ignored; exactly one done, in cycle 21.
  - busy=0 in cycle 21 and stays low after it.
- rst asserted in cycle 10:
  - All outputs 0 in cycle 11; no done.
  - A new start in cycle 12 issues nibble 0 in cycle 13.
- start held high continuously:
  - done in cycle 21, busy=1 again in cycle 22, with sb_en[0]=1 and sb_in_sel=0.
  - done again in cycle 42.
- NIBBLES=2, STAGES=1, start in cycle 0:
  - Issues in cycles 1 and 2; writes in cycles 2 and 3 (sel 0, 1).
  - done in cycle 4.
